robotben_plant_model: RTL and testbench

- Behavioural plant/sensor model for the robot workcell: the sensing end of the robot controller's actuator interface.
- Consumes the 43-bit actuator command vector (bit k-1 = actuator line y_k) and produces the five sensor lines x1..x5 with timed, stateful responses.
- Used as closed-loop stimulus for controller verification, and as a protocol checker that flags illegal command sequences.

---
 rtl/robotben_plant_model_if.sv | 27 ++
 rtl/robotben_plant_model.sv | 179 +++++++++++++++++
 tb/tb_robotben_plant_model.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/robotben_plant_model_if.sv
// Actuator-command / sensor bundle between the robot controller and the plant model.
interface robotben_plant_model_if #(
  parameter int CW = 8
);
  logic [42:0]   cmd;
  logic          part_in;
  logic          bin_clear;
  logic          x1;
  logic          x2;
  logic          x3;
  logic          x4;
  logic          x5;
  logic [CW-1:0] done_count;
  logic          proto_err;

  // Controller side: drives actuator commands and environment pulses, reads sensors.
  modport master (
    output cmd, part_in, bin_clear,
    input  x1, x2, x3, x4, x5, done_count, proto_err
  );

  // Plant side: consumes commands, produces the sensor lines.
  modport slave (
    input  cmd, part_in, bin_clear,
    output x1, x2, x3, x4, x5, done_count, proto_err
  );
endinterface

// File: rtl/robotben_plant_model.sv
// Workcell plant/sensor model: timed arm, clamp and feeder responses, part
// presence, bin counter, and a sticky flag for illegal command sequences.
module robotben_plant_model #(
  parameter int ARM_LAT   = 4,
  parameter int CLAMP_LEN = 6,
  parameter int FEED_LEN  = 3,
  parameter int BIN_CAP   = 5,
  parameter int CW        = 8
) (
  input  logic clk,
  input  logic rst,
  robotben_plant_model_if.slave bus
);

  typedef enum logic [1:0] {ARM_IDLE, ARM_MOVING, ARM_READY} arm_state_t;
  typedef enum logic       {TMR_IDLE, TMR_BUSY} tmr_state_t;

  arm_state_t    arm_st, arm_st_nxt;
  tmr_state_t    cl_st, cl_st_nxt, fd_st, fd_st_nxt;
  logic [CW-1:0] arm_cnt, arm_cnt_nxt;
  logic [CW-1:0] cl_cnt, cl_cnt_nxt;
  logic [CW-1:0] fd_cnt, fd_cnt_nxt;
  logic [CW-1:0] done_q, done_nxt;
  logic          x1_q, x1_nxt;
  logic          x2_q, x2_nxt;
  logic          x3_q, x3_nxt;
  logic          x4_q, x4_nxt;
  logic          x5_q, x5_nxt;
  logic          err_q, err_nxt;

  logic arm_trig, cl_trig, fd_trig, pick, deposit;
  assign arm_trig = bus.cmd[33];
  assign cl_trig  = bus.cmd[27];
  assign fd_trig  = bus.cmd[11];
  assign pick     = bus.cmd[12];
  assign deposit  = bus.cmd[1];

  // Remaining command lines belong to other parts of the workcell.
  logic unused_cmd;
  assign unused_cmd = ^{bus.cmd[42:34], bus.cmd[32:28], bus.cmd[26:13],
                        bus.cmd[10:2], bus.cmd[0]};

  // State register; reset aborts every timer at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_st  <= ARM_IDLE;
      cl_st   <= TMR_IDLE;
      fd_st   <= TMR_IDLE;
      arm_cnt <= '0;
      cl_cnt  <= '0;
      fd_cnt  <= '0;
      done_q  <= '0;
      x1_q    <= 1'b0;
      x2_q    <= 1'b0;
      x3_q    <= 1'b0;
      x4_q    <= 1'b0;
      x5_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      arm_st  <= arm_st_nxt;
      cl_st   <= cl_st_nxt;
      fd_st   <= fd_st_nxt;
      arm_cnt <= arm_cnt_nxt;
      cl_cnt  <= cl_cnt_nxt;
      fd_cnt  <= fd_cnt_nxt;
      done_q  <= done_nxt;
      x1_q    <= x1_nxt;
      x2_q    <= x2_nxt;
      x3_q    <= x3_nxt;
      x4_q    <= x4_nxt;
      x5_q    <= x5_nxt;
      err_q   <= err_nxt;
    end
  end

  // Next-state for all three FSMs plus part, bin and error tracking.
  always_comb begin
    arm_st_nxt  = arm_st;
    cl_st_nxt   = cl_st;
    fd_st_nxt   = fd_st;
    arm_cnt_nxt = arm_cnt;
    cl_cnt_nxt  = cl_cnt;
    fd_cnt_nxt  = fd_cnt;
    done_nxt    = done_q;
    x1_nxt      = x1_q;
    x2_nxt      = x2_q;
    x3_nxt      = x3_q;
    x4_nxt      = x4_q;
    err_nxt     = err_q;

    // Arm: retrigger while moving is harmless and does not restart the timer.
    case (arm_st)
      ARM_MOVING: begin
        if (arm_cnt == CW'(1)) begin
          arm_cnt_nxt = '0;
          x1_nxt      = 1'b1;
          arm_st_nxt  = ARM_READY;
        end else begin
          arm_cnt_nxt = arm_cnt - CW'(1);
        end
      end
      default: begin
        if (arm_trig) begin
          arm_cnt_nxt = CW'(ARM_LAT);
          x1_nxt      = 1'b0;
          arm_st_nxt  = ARM_MOVING;
        end
      end
    endcase

    // Clamp: any trigger seen in BUSY, including the exit edge, is a violation.
    case (cl_st)
      TMR_BUSY: begin
        if (cl_trig) err_nxt = 1'b1;
        if (cl_cnt == CW'(1)) begin
          cl_cnt_nxt = '0;
          x2_nxt     = 1'b0;
          cl_st_nxt  = TMR_IDLE;
        end else begin
          cl_cnt_nxt = cl_cnt - CW'(1);
        end
      end
      default: begin
        if (cl_trig) begin
          cl_cnt_nxt = CW'(CLAMP_LEN);
          x2_nxt     = 1'b1;
          cl_st_nxt  = TMR_BUSY;
        end
      end
    endcase

    // Feeder: same protocol as the clamp.
    case (fd_st)
      TMR_BUSY: begin
        if (fd_trig) err_nxt = 1'b1;
        if (fd_cnt == CW'(1)) begin
          fd_cnt_nxt = '0;
          x3_nxt     = 1'b0;
          fd_st_nxt  = TMR_IDLE;
        end else begin
          fd_cnt_nxt = fd_cnt - CW'(1);
        end
      end
      default: begin
        if (fd_trig) begin
          fd_cnt_nxt = CW'(FEED_LEN);
          x3_nxt     = 1'b1;
          fd_st_nxt  = TMR_BUSY;
        end
      end
    endcase

    // Part present: an arriving part wins over a same-edge pick.
    if (bus.part_in) begin
      x4_nxt = 1'b1;
    end else if (pick) begin
      if (!x4_q) err_nxt = 1'b1;
      x4_nxt = 1'b0;
    end

    // Bin counter: clear with a same-edge deposit leaves one part counted.
    if (bus.bin_clear)
      done_nxt = deposit ? CW'(1) : '0;
    else if (deposit && done_q != '1)
      done_nxt = done_q + CW'(1);

    // x5 follows the counter's next value so both change on the same edge.
    x5_nxt = (done_nxt >= CW'(BIN_CAP));
  end

  assign bus.x1         = x1_q;
  assign bus.x2         = x2_q;
  assign bus.x3         = x3_q;
  assign bus.x4         = x4_q;
  assign bus.x5         = x5_q;
  assign bus.done_count = done_q;
  assign bus.proto_err  = err_q;

endmodule

// File: tb/tb_robotben_plant_model.sv
// Bench for robotben_plant_model: directed scenarios plus random commands,
// all checked against an edge-indexed behavioural model.
module tb_robotben_plant_model;
  localparam int ARM_LAT   = 4;
  localparam int CLAMP_LEN = 6;
  localparam int FEED_LEN  = 3;
  localparam int BIN_CAP   = 5;
  localparam int CW        = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  robotben_plant_model_if #(.CW(CW)) bus ();

  robotben_plant_model #(
    .ARM_LAT(ARM_LAT), .CLAMP_LEN(CLAMP_LEN), .FEED_LEN(FEED_LEN),
    .BIN_CAP(BIN_CAP), .CW(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // Model: each timer is described by the edge index at which it was started.
  int cyc, arm_start, cl_start, fd_start, m_done;
  bit arm_seen, m_x4, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; arm_start = -1000; cl_start = -1000; fd_start = -1000;
    arm_seen = 0; m_x4 = 0; m_err = 0; m_done = 0;
  endtask

  task automatic model_edge(input logic [42:0] c, input logic p, input logic b);
    cyc++;
    if (c[33] && (!arm_seen || cyc > arm_start + ARM_LAT)) begin
      arm_start = cyc; arm_seen = 1;
    end
    if (c[27]) begin
      if (cyc > cl_start + CLAMP_LEN) cl_start = cyc; else m_err = 1;
    end
    if (c[11]) begin
      if (cyc > fd_start + FEED_LEN) fd_start = cyc; else m_err = 1;
    end
    if (p) m_x4 = 1;
    else if (c[12]) begin
      if (!m_x4) m_err = 1;
      m_x4 = 0;
    end
    if (b) m_done = c[1] ? 1 : 0;
    else if (c[1] && m_done < (1 << CW) - 1) m_done++;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".x1"}, 32'(bus.x1), 32'(arm_seen && cyc >= arm_start + ARM_LAT));
    chk({tag, ".x2"}, 32'(bus.x2), 32'(cyc >= cl_start && cyc < cl_start + CLAMP_LEN));
    chk({tag, ".x3"}, 32'(bus.x3), 32'(fd_start <= cyc && cyc < fd_start + FEED_LEN));
    chk({tag, ".x4"}, 32'(bus.x4), 32'(m_x4));
    chk({tag, ".x5"}, 32'(bus.x5), 32'(m_done >= BIN_CAP));
    chk({tag, ".done"}, 32'(bus.done_count), 32'(m_done));
    chk({tag, ".err"}, 32'(bus.proto_err), 32'(m_err));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".x1"}, 32'(bus.x1), 0);
    chk({tag, ".x2"}, 32'(bus.x2), 0);
    chk({tag, ".x3"}, 32'(bus.x3), 0);
    chk({tag, ".x4"}, 32'(bus.x4), 0);
    chk({tag, ".x5"}, 32'(bus.x5), 0);
    chk({tag, ".done"}, 32'(bus.done_count), 0);
    chk({tag, ".err"}, 32'(bus.proto_err), 0);
  endtask

  // Drive one cycle of inputs, advance the model on the edge, check 1ns later.
  task automatic step(input logic [42:0] c, input logic p, input logic b, input string tag);
    bus.cmd = c; bus.part_in = p; bus.bin_clear = b;
    @(posedge clk);
    model_edge(c, p, b);
    #1 check_all(tag);
    bus.cmd = '0; bus.part_in = 1'b0; bus.bin_clear = 1'b0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0, tag);
  endtask

  // Reset asserted away from any edge; outputs must clear before the next edge.
  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1 check_zero(tag);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [42:0] bit_of(input int k);
    logic [42:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  logic [63:0] rnd;
  logic [42:0] rc;

  initial begin
    rst = 1'b1;
    bus.cmd = '0; bus.part_in = 1'b0; bus.bin_clear = 1'b0;
    model_reset();
    #12 check_zero("por");
    @(negedge clk);
    rst = 1'b0;

    // Arm: triggers during MOVING are ignored; retrigger from READY restarts.
    step(bit_of(33), 0, 0, "arm_e0");
    step(bit_of(33), 0, 0, "arm_e1");
    step(bit_of(33), 0, 0, "arm_e2");
    idle(1, "arm_e3");
    idle(1, "arm_e4");
    chk("arm_rise", 32'(bus.x1), 1);
    idle(1, "arm_e5");
    step(bit_of(33), 0, 0, "arm_e6");
    chk("arm_drop", 32'(bus.x1), 0);
    idle(4, "arm_e10");
    chk("arm_rerise", 32'(bus.x1), 1);

    // Clamp: second pulse mid-burst is a violation and leaves timing intact.
    do_reset("rst1");
    step(bit_of(27), 0, 0, "clamp_e0");
    idle(2, "clamp_e2");
    step(bit_of(27), 0, 0, "clamp_e3");
    chk("clamp_err", 32'(bus.proto_err), 1);
    idle(3, "clamp_tail");
    chk("clamp_fall", 32'(bus.x2), 0);

    // Feeder: retrigger one edge after the fall is legal.
    do_reset("rst2");
    step(bit_of(11), 0, 0, "feed_e0");
    idle(3, "feed_run");
    step(bit_of(11), 0, 0, "feed_re");
    idle(3, "feed_run2");
    chk("feed_noerr", 32'(bus.proto_err), 0);

    // Exit-edge retrigger of the feeder counts as a violation.
    step(bit_of(11), 0, 0, "feed_x0");
    idle(2, "feed_x1");
    step(bit_of(11), 0, 0, "feed_exit");
    chk("feed_exit_err", 32'(bus.proto_err), 1);

    // Part present.
    do_reset("rst3");
    step('0, 1, 0, "part_in");
    step(bit_of(12), 0, 0, "pick");
    step(bit_of(12), 1, 0, "pick_and_in");
    chk("pick_and_in_x4", 32'(bus.x4), 1);
    step(bit_of(12), 0, 0, "pick2");
    step(bit_of(12), 0, 0, "pick_empty");
    chk("pick_empty_err", 32'(bus.proto_err), 1);

    // Bin counter and full flag.
    do_reset("rst4");
    for (int i = 0; i < 5; i++) step(bit_of(1), 0, 0, "deposit");
    chk("bin_full", 32'(bus.x5), 1);
    step(bit_of(1), 0, 1, "clear_dep");
    chk("clear_dep_cnt", 32'(bus.done_count), 1);

    // Reset while all three timers are running.
    do_reset("rst5");
    step(bit_of(27) | bit_of(11) | bit_of(33), 0, 0, "all_busy");
    idle(1, "all_busy2");
    do_reset("rst_mid");
    step(bit_of(27), 0, 0, "clamp2_e0");
    idle(6, "clamp2_run");

    // Random commands, other lines random as don't-cares.
    do_reset("rst6");
    for (int i = 0; i < 600; i++) begin
      rnd = {$urandom(), $urandom()};
      rc = rnd[42:0];
      rc[33] = ($urandom_range(0, 9) == 0);
      rc[27] = ($urandom_range(0, 7) == 0);
      rc[11] = ($urandom_range(0, 5) == 0);
      rc[12] = ($urandom_range(0, 4) == 0);
      rc[1]  = ($urandom_range(0, 2) == 0);
      step(rc, ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0), "rand");
    end

    // Saturation.
    do_reset("rst7");
    for (int i = 0; i < 300; i++) step(bit_of(1), 0, 0, "sat");
    chk("sat_cnt", 32'(bus.done_count), 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so a stalled run still ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
